z80_mcycle_sequencer: RTL
=========================

# z80_mcycle_sequencer

Bus machine-cycle sequencer for the Z80 core: accepts one machine-cycle command at a time from the instruction decoder and drives the external bus strobes T-state by T-state. Supported cycles are M1 opcode fetch, memory read/write and I/O read/write, with WAIT_n insertion. It reports the T-state count of each completed cycle so the z80fi spec checkers (mcycle_type/tcycles) can be compared cycle-for-cycle. One clock edge equals one T-state; half-T-state strobe timing is not modelled.

## Interface
- No parameters.
- clk  in  1  T-state clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted this clock when high with cmd_valid.
- cmd_type  in  3  cycle type, `z80_mcycle_pkg` encoding.
- cmd_addr  in  16  cycle address (PC for M1).
- cmd_wdata  in  8  write data.
- reg_i, reg_r  in  8, 8  refresh address source.
- wait_n  in  1  bus WAIT, active-low.
- bus_din  in  8  bus read data.
- bus_addr  out  16  address bus.
- bus_dout  out  8  write data.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  out  1 each  active-low strobes.
- done  out  1  one-clock pulse in the final T-state of a cycle.
- rdata  out  8  captured read data, valid from done until the next capture.
- tcycles  out  4  T-states of the last completed cycle, including waits.
- r_inc  out  1  one-clock pulse requesting R[6:0]+1 (R[7] preserved).

## Operation
- States: IDLE, T1, T2, TW, T3, T4.
- cmd_ready = (state==IDLE) || done. cmd_type, cmd_addr and cmd_wdata are registered on acceptance; the next clock is T1. Back-to-back acceptance on done gives T1 immediately after the final T-state, with no idle gap.
- CYCLE_NONE: accepted, no strobes, done pulses on the next clock with tcycles=0, then IDLE.
- M1:
  - T1/T2: bus_addr=addr, m1_n=mreq_n=rd_n=0.
  - wait_n is sampled in T2 and each TW. Low means enter or stay in TW.
  - bus_din is captured into rdata on the edge leaving the last of T2/TW.
  - T3/T4: m1_n=rd_n=1, mreq_n=0, rfsh_n=0, bus_addr={reg_i,reg_r}.
  - done in T4; r_inc in T4.
- Memory read:
  - T1–T3: mreq_n=rd_n=0. Waits are sampled as for M1.
  - rdata is captured on the edge leaving T3. done in T3.
- Memory write:
  - T1–T3: mreq_n=0 and bus_dout=wdata.
  - wr_n=0 in T2, TW and T3.
  - done in T3.
- I/O read/write:
  - One TW is always inserted after T2, then wait_n is sampled in each TW.
  - iorq_n=0 from T2 through T3; rd_n or wr_n follows the same window.
  - I/O read captures rdata leaving T3.
- tcycles counts every T-state including TW and saturates at 15.
- Undefined cmd_type (6, 7): treated as CYCLE_NONE.

## Timing
- Reset values:
  - State IDLE; all strobes 1; bus_addr=0, bus_dout=0, rdata=0, tcycles=0.
  - done=0, r_inc=0, cmd_ready=1.
- Reset mid-cycle forces IDLE asynchronously; strobes deassert immediately and no done is issued.
- Minimum lengths with wait_n=1: M1 4, memory read/write 3, I/O 4.
- Each wait_n=0 sample adds exactly one T-state.
- All outputs are registered or decoded from registered state only. cmd_valid and wait_n have no combinational path to the strobes.
- The command is accepted at edge k and T1 is state k+1. done is high for exactly one clock per accepted command.

## Configuration
- Z80_REFRESH_EN defined: M1 T3/T4 refresh behaviour as above (rfsh_n, {I,R} address, r_inc).
- Z80_REFRESH_EN undefined:
  - rfsh_n stays 1, r_inc stays 0, and mreq_n is deasserted in T3/T4.
  - bus_addr holds the opcode address in T3/T4.
  - Timing is unchanged (M1 is still 4 T-states).

## Structure
- `z80_mcycle_pkg` holds the cycle type constants shared with the z80fi spec: CYCLE_NONE=0, CYCLE_M1=1, CYCLE_RD_MEM=2, CYCLE_WR_MEM=3, CYCLE_RD_IO=4, CYCLE_WR_IO=5.
- The package also holds the T-state enum (IDLE, T1, T2, TW, T3, T4).
- No sub-module: one FSM plus a strobe decode.

## Test plan
- M1 at 0x1234, wait_n=1, bus_din=0x3A, I=0x12, R=0x05: 4 T-states, address 0x1234 in T1–T2 then 0x1205 in T3/T4, rfsh_n=0 in T3/T4, rdata=0x3A, tcycles=4, r_inc once.
- Memory read at 0xBEEF with wait_n=0 for 2 samples: sequence T1 T2 TW TW T3, rdata=bus_din, tcycles=5.
- Memory write of 0x5A at 0x8000 followed back-to-back by M1: wr_n low in T2–T3 only, bus_dout=0x5A, next T1 directly after done, tcycles=3 then 4.
- I/O read at port 0x00FE, wait_n=1: forced single TW, iorq_n low T2–T3, tcycles=4.
- reset asserted during TW of a memory read: strobes high immediately, no done; a new M1 accepted after release runs normally.
- CYCLE_NONE, then cmd_type=7: each gives done one clock later with tcycles=0 and no strobe activity; build again without Z80_REFRESH_EN and rerun the first scenario, expecting rfsh_n constant 1 and address 0x1234 in T3/T4.

Source files
------------

// File: rtl/z80_mcycle_pkg.sv
// Machine-cycle type codes (shared with the z80fi checkers) and the T-state encoding
// used by the Z80 bus sequencer.
package z80_mcycle_pkg;

    typedef enum logic [2:0] {
        CYCLE_NONE   = 3'd0,
        CYCLE_M1     = 3'd1,
        CYCLE_RD_MEM = 3'd2,
        CYCLE_WR_MEM = 3'd3,
        CYCLE_RD_IO  = 3'd4,
        CYCLE_WR_IO  = 3'd5
    } cycle_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } tstate_t;

    localparam logic [3:0] TCYCLES_MAX = 4'd15;

    // Codes 6 and 7 are not real cycles; they complete like CYCLE_NONE.
    function automatic cycle_t decode_cycle(input logic [2:0] raw);
        case (raw)
            3'd1:    return CYCLE_M1;
            3'd2:    return CYCLE_RD_MEM;
            3'd3:    return CYCLE_WR_MEM;
            3'd4:    return CYCLE_RD_IO;
            3'd5:    return CYCLE_WR_IO;
            default: return CYCLE_NONE;
        endcase
    endfunction

    function automatic logic is_io_cycle(input cycle_t c);
        return (c == CYCLE_RD_IO) || (c == CYCLE_WR_IO);
    endfunction

    function automatic logic is_read_capture_late(input cycle_t c);
        return (c == CYCLE_RD_MEM) || (c == CYCLE_RD_IO);
    endfunction

endpackage

// File: rtl/z80_mcycle_sequencer.sv
// Z80 bus machine-cycle sequencer: one command at a time, strobes decoded per T-state.
// Optional macro Z80_REFRESH_EN enables the M1 refresh phase (rfsh_n, {I,R} address, r_inc).
//
// state | meaning
// IDLE  | no cycle in progress, ready for a command
// T1    | first T-state (final one for CYCLE_NONE)
// T2    | second T-state, WAIT sampled here except for I/O
// TW    | wait state, WAIT sampled every clock
// T3    | third T-state, final for memory and I/O cycles
// T4    | M1 refresh tail, final for M1
module z80_mcycle_sequencer
    import z80_mcycle_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_type,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic [7:0]  reg_i,
    input  logic [7:0]  reg_r,
    input  logic        wait_n,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        m1_n,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        rfsh_n,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [3:0]  tcycles,
    output logic        r_inc
);

    tstate_t     state, state_nxt;
    cycle_t      cyc;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [3:0]  tcnt;
    logic        last_t;
    logic        capture;
    logic        accept;

    always_comb begin
        last_t = 1'b0;
        case (state)
            T1:      last_t = (cyc == CYCLE_NONE);
            T3:      last_t = (cyc != CYCLE_M1);
            T4:      last_t = 1'b1;
            default: last_t = 1'b0;
        endcase
    end

    assign done      = last_t;
    assign cmd_ready = (state == IDLE) || last_t;
    assign accept    = cmd_valid && cmd_ready;

    // A command presented during the final T-state starts its T1 on the very next edge.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = T1;
            end
            T1: begin
                if (cyc == CYCLE_NONE) state_nxt = cmd_valid ? T1 : IDLE;
                else                   state_nxt = T2;
            end
            T2: begin
                if (is_io_cycle(cyc)) begin
                    state_nxt = TW;
                end else if (wait_n) begin
                    state_nxt = T3;
                    capture   = (cyc == CYCLE_M1);
                end else begin
                    state_nxt = TW;
                end
            end
            TW: begin
                if (wait_n) begin
                    state_nxt = T3;
                    capture   = (cyc == CYCLE_M1);
                end
            end
            T3: begin
                if (cyc == CYCLE_M1) begin
                    state_nxt = T4;
                end else begin
                    state_nxt = cmd_valid ? T1 : IDLE;
                    capture   = is_read_capture_late(cyc);
                end
            end
            T4: begin
                state_nxt = cmd_valid ? T1 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cyc     <= CYCLE_NONE;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            tcnt    <= 4'd0;
            rdata   <= 8'h00;
            tcycles <= 4'd0;
        end else begin
            state <= state_nxt;
            if (capture) rdata <= bus_din;
            if (last_t) tcycles <= (cyc == CYCLE_NONE) ? 4'd0 : tcnt;
            if (accept) begin
                cyc     <= decode_cycle(cmd_type);
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                tcnt    <= 4'd1;
            end else if (tcnt != TCYCLES_MAX) begin
                tcnt <= tcnt + 4'd1;
            end
        end
    end

`ifndef Z80_REFRESH_EN
    logic unused_refresh_src;
    assign unused_refresh_src = ^{reg_i, reg_r};
`endif

    always_comb begin
        m1_n     = 1'b1;
        mreq_n   = 1'b1;
        iorq_n   = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        rfsh_n   = 1'b1;
        r_inc    = 1'b0;
        bus_addr = 16'h0000;
        bus_dout = 8'h00;
        if (state != IDLE) begin
            case (cyc)
                CYCLE_M1: begin
                    if ((state == T3) || (state == T4)) begin
`ifdef Z80_REFRESH_EN
                        mreq_n   = 1'b0;
                        rfsh_n   = 1'b0;
                        bus_addr = {reg_i, reg_r};
                        r_inc    = (state == T4);
`else
                        bus_addr = addr_q;
`endif
                    end else begin
                        m1_n     = 1'b0;
                        mreq_n   = 1'b0;
                        rd_n     = 1'b0;
                        bus_addr = addr_q;
                    end
                end
                CYCLE_RD_MEM: begin
                    mreq_n   = 1'b0;
                    rd_n     = 1'b0;
                    bus_addr = addr_q;
                end
                CYCLE_WR_MEM: begin
                    mreq_n   = 1'b0;
                    wr_n     = (state == T1);
                    bus_addr = addr_q;
                    bus_dout = wdata_q;
                end
                CYCLE_RD_IO: begin
                    iorq_n   = (state == T1);
                    rd_n     = (state == T1);
                    bus_addr = addr_q;
                end
                CYCLE_WR_IO: begin
                    iorq_n   = (state == T1);
                    wr_n     = (state == T1);
                    bus_addr = addr_q;
                    bus_dout = wdata_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
